// File: rtl/cbfp1_frame_ctrl.sv
// rtl/cbfp1_frame_ctrl.sv - CBFP stage-1 frame sequencer, tag pipeline and block-index FIFO
// Optional sticky error register enabled by defining CBFP1_CTRL_ERR_EN.
module cbfp1_frame_ctrl #(
    parameter int NCHAN       = 16,
    parameter int BLOCK_SIZE  = 8,
    parameter int NBLOCKS     = NCHAN / BLOCK_SIZE,
    parameter int IDX_W       = 5,
    parameter int FRAME_BEATS = 32,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              in_sof,
    output logic                              in_ready,
    output logic                              dp_valid_in,
    input  logic [NBLOCKS*IDX_W-1:0]          dp_idx,
    input  logic                              dp_valid_out,
    output logic                              out_sof,
    output logic                              out_eof,
    output logic [$clog2(FRAME_BEATS)-1:0]    out_beat,
    output logic                              frame_done,
    input  logic                              idx_rd_en,
    output logic [NBLOCKS*IDX_W-1:0]          idx_rd_data,
    output logic                              idx_empty,
    output logic [$clog2(FIFO_DEPTH):0]       idx_count,
    output logic [2:0]                        err,
    input  logic                              err_clr
);
    localparam int BEAT_W = $clog2(FRAME_BEATS);
    localparam int DW     = NBLOCKS * IDX_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt, cur_beat;
    logic                accepted, fwd, last_beat, pop;
    logic                sof_q, eof_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;

    // A same-cycle pop deliberately does not open in_ready, keeping the path short.
    assign in_ready  = (idx_count < CNT_W'(FIFO_DEPTH)) & ~rst;
    assign accepted  = in_valid & in_ready;
    assign idx_empty = (idx_count == '0);
    assign pop       = idx_rd_en & ~idx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // beat_cnt holds the number the next non-sof beat will carry.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        if (fwd) begin
            beat_cnt_nxt = cur_beat + BEAT_W'(1);
            state_nxt    = last_beat ? IDLE : RUN;
        end
    end

    always_comb begin
        cur_beat    = in_sof ? '0 : beat_cnt;
        last_beat   = (cur_beat == BEAT_W'(FRAME_BEATS - 1));
        fwd         = accepted & ((state == RUN) | in_sof);
        dp_valid_in = fwd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            sof_q  <= fwd & in_sof;
            eof_q  <= fwd & last_beat;
            beat_q <= fwd ? cur_beat : '0;
        end
    end

    assign out_sof    = sof_q & dp_valid_out;
    assign out_eof    = eof_q & dp_valid_out;
    assign out_beat   = beat_q & {BEAT_W{dp_valid_out}};
    assign frame_done = out_eof;

    always_ff @(posedge clk) begin
        if (fwd) mem[wr_ptr] <= dp_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            idx_count <= '0;
        end else begin
            if (fwd) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            idx_count <= idx_count + CNT_W'(fwd) - CNT_W'(pop);
        end
    end

    assign idx_rd_data = mem[rd_ptr];

`ifdef CBFP1_CTRL_ERR_EN
    logic [2:0] err_ev;

    assign err_ev = {idx_rd_en & idx_empty,
                     accepted & (state == RUN) & in_sof & (beat_cnt != '0),
                     accepted & (state == IDLE) & ~in_sof};

    // A new event in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) err <= '0;
        else     err <= (err_clr ? 3'b000 : err) | err_ev;
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = '0;
`endif
endmodule

// File: tb/tb_cbfp1_frame_ctrl.sv
// tb/tb_cbfp1_frame_ctrl.sv - scoreboard bench for cbfp1_frame_ctrl
module tb_cbfp1_frame_ctrl;
    localparam int DW = 10;
    localparam int BW = 5;
    localparam int CW = 5;
    localparam int FB = 32;
    localparam int FD = 16;
`ifdef CBFP1_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
    logic dp_valid_out = 1'b0, idx_rd_en = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] dp_idx = '0;
    logic in_ready, dp_valid_in, out_sof, out_eof, frame_done, idx_empty;
    logic [BW-1:0] out_beat;
    logic [DW-1:0] idx_rd_data;
    logic [CW-1:0] idx_count;
    logic [2:0]    err;

    cbfp1_frame_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .dp_valid_in(dp_valid_in), .dp_idx(dp_idx), .dp_valid_out(dp_valid_out),
        .out_sof(out_sof), .out_eof(out_eof), .out_beat(out_beat), .frame_done(frame_done),
        .idx_rd_en(idx_rd_en), .idx_rd_data(idx_rd_data), .idx_empty(idx_empty),
        .idx_count(idx_count), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) dp_valid_out <= dp_valid_in;

    typedef struct {
        logic       rdy;
        logic       fwd;
        logic       empty;
        logic [4:0] count;
        logic [2:0] err;
    } st_t;
    typedef struct {
        logic       sof;
        logic       eof;
        logic [4:0] beat;
    } tag_t;

    st_t           st_q[$];
    tag_t          tag_q[$];
    logic [DW-1:0] pop_q[$];
    logic [DW-1:0] m_q[$];
    bit            m_run = 1'b0;
    int            m_pos = 0;
    logic [2:0]    m_err = 3'b000;
    bit            m_acc;
    int            gen_pos = 0;
    int            n_cmp = 0, n_bad = 0;
    bit            running = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input bit s, input bit rd, input bit r, input bit clr,
                        input logic [DW-1:0] d);
        st_t  e;
        tag_t t;
        bit   fwd;
        int   beat;
        int   sz;
        logic [2:0] ev;
        @(posedge clk);
        #1;
        in_valid = v; in_sof = s; idx_rd_en = rd; rst = r; err_clr = clr; dp_idx = d;
        sz    = m_q.size();
        m_acc = v && !r && (sz < FD);
        fwd   = m_acc && (m_run || s);
        e.rdy = !r && (sz < FD);
        e.fwd = fwd;
        e.count = 5'(sz);
        e.empty = (sz == 0);
        e.err = ERR_EN ? m_err : 3'b000;
        st_q.push_back(e);
        ev = {rd && (sz == 0), m_acc && m_run && s && (m_pos != 0), m_acc && !m_run && !s};
        beat = s ? 0 : m_pos;
        if (fwd) begin
            t.sof = (beat == 0);
            t.eof = (beat == FB - 1);
            t.beat = 5'(beat);
            tag_q.push_back(t);
        end
        if (r) begin
            m_run = 1'b0; m_pos = 0; m_err = 3'b000;
            m_q.delete();
        end else begin
            if (rd && sz > 0) begin
                pop_q.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (fwd) begin
                m_q.push_back(d);
                m_pos = beat + 1;
                m_run = (beat != FB - 1);
            end
            m_err = (clr ? 3'b000 : m_err) | ev;
        end
    endtask

    st_t  me;
    tag_t mt;
    always @(negedge clk) begin
        if (running) begin
            if (st_q.size() == 0) chk("state_queue_empty", 0, 1);
            else begin
                me = st_q.pop_front();
                chk("in_ready", int'(in_ready), int'(me.rdy));
                chk("dp_valid_in", int'(dp_valid_in), int'(me.fwd));
                chk("idx_count", int'(idx_count), int'(me.count));
                chk("idx_empty", int'(idx_empty), int'(me.empty));
                chk("err", int'(err), int'(me.err));
            end
            if (dp_valid_out) begin
                if (tag_q.size() == 0) chk("tag_queue_empty", 0, 1);
                else begin
                    mt = tag_q.pop_front();
                    chk("out_sof", int'(out_sof), int'(mt.sof));
                    chk("out_eof", int'(out_eof), int'(mt.eof));
                    chk("frame_done", int'(frame_done), int'(mt.eof));
                    chk("out_beat", int'(out_beat), int'(mt.beat));
                end
            end else begin
                chk("tags_idle", int'({out_sof, out_eof, frame_done, out_beat}), 0);
            end
            if (idx_rd_en && !idx_empty) begin
                if (pop_q.size() == 0) chk("pop_queue_empty", 0, 1);
                else chk("idx_rd_data", int'(idx_rd_data), int'(pop_q.pop_front()));
            end
        end
    end

    initial begin
        bit s;
        repeat (3) step(0, 0, 0, 1, 0, '0);
        // 32 sof-led beats with no pops: FIFO fills at 16 and stalls
        for (int i = 0; i < 32; i++) step(1, i == 0, 0, 0, 0, DW'(i));
        repeat (3) step(1, 0, 1, 0, 0, DW'($urandom));
        repeat (20) step(0, 0, 1, 0, 0, '0);
        // orphan beats in IDLE, then clear
        step(0, 0, 0, 1, 0, '0);
        repeat (3) step(1, 0, 0, 0, 0, DW'($urandom));
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 0, 0, '0);
        // early sof at beat 10, then a full frame
        step(1, 1, 1, 0, 0, DW'($urandom));
        repeat (9) step(1, 0, 1, 0, 0, DW'($urandom));
        step(1, 1, 1, 0, 0, DW'($urandom));
        repeat (31) step(1, 0, 1, 0, 0, DW'($urandom));
        // two back-to-back frames with continuous pops
        for (int i = 0; i < 64; i++) step(1, (i % FB) == 0, 1, 0, 0, DW'($urandom));
        repeat (4) step(0, 0, 1, 0, 0, '0);
        // reset mid-frame with entries queued
        for (int i = 0; i < 20; i++) step(1, i == 0, i < 15, 0, 0, DW'($urandom));
        step(1, 0, 0, 1, 0, '0);
        repeat (3) step(1, 0, 1, 0, 0, DW'($urandom));
        // randomized traffic
        gen_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v, rd, r, clr;
            v   = ($urandom % 4) != 0;
            s   = (gen_pos == 0) ? (($urandom % 16) != 0) : (($urandom % 48) == 0);
            r   = ($urandom % 400) == 0;
            rd  = !r && (($urandom % 8) < 5);
            clr = ($urandom % 50) == 0;
            step(v, s, rd, r, clr, DW'($urandom));
            if (r) gen_pos = 0;
            else if (m_acc) gen_pos = s ? 1 : (gen_pos + 1) % FB;
        end
        repeat (4) step(0, 0, 0, 0, 0, '0);
        repeat (20) step(0, 0, m_q.size() > 0, 0, 0, '0);
        repeat (3) step(0, 0, 0, 0, 0, '0);
        @(negedge clk);
        #1 running = 1'b0;
        chk("tags_left", tag_q.size(), 0);
        chk("pops_left", pop_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
